seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25000, clocks per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter DEAD, default 500, anode-off clocks at each slot start; legal range 1..CLK_DIV-2.
REQ-003 SHALL have parameter BLINK_SCANS, default 250, full 4-digit scans per blink half-period; legal range 1..1023.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  1 = display on, 0 = all anodes off with counters running.
REQ-007 SHALL have ports digit0..digit3  input  8 each  digit control bytes from the EPP register file: [3:0] hex value, [4] dp on, [5] blank, [6] blink, [7] ignored.
REQ-008 SHALL have port an  output  4  anode enables, active-low; an[i] drives digit i.
REQ-009 SHALL have port seg  output  7  cathodes, active-low; seg[0]=a .. seg[6]=g.
REQ-010 SHALL have port dp  output  1  decimal point cathode, active-low.

Function
REQ-011 SHALL keep slot counter cnt, counting 0..CLK_DIV-1 and wrapping to 0.
REQ-012 SHALL keep digit index idx (2 bits); it increments modulo 4 when cnt wraps.
REQ-013 SHALL keep scan counter scn, incrementing when idx wraps 3->0; when scn reaches BLINK_SCANS-1 and idx wraps, scn goes to 0 and blink_phase toggles.
REQ-014 SHALL load a shadow byte from digit[idx] on the cycle cnt==0; input changes at any other time SHALL NOT affect the lit digit until its next slot.
REQ-015 SHALL register an, seg and dp; outputs at cycle t+1 reflect cnt, idx, blink_phase, enable and shadow at cycle t.
REQ-016 SHALL drive an=4'b1111 whenever cnt<DEAD, enable==0, shadow[5]==1, or (shadow[6]==1 and blink_phase==1); otherwise an[idx]=0 and the other three bits 1.
REQ-017 SHALL drive seg from shadow[3:0] using the active-low font: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-018 SHALL drive dp=~shadow[4]; seg and dp update even while an is all ones.
REQ-019 SHALL not change blink_phase, scn, cnt or idx in response to enable, blank or blink bits.
REQ-020 SHALL guarantee at most one an bit low in any cycle, and all ones for at least DEAD cycles between two different digits being lit.

Reset
REQ-021 SHALL, while rst==1, asynchronously force cnt=0, idx=0, scn=0, blink_phase=0, shadow=8'h20 (blank), an=4'b1111, seg=7'h7F, dp=1.
REQ-022 SHALL, after rst deasserts, start with idx=0 and cnt=0 on the first clock edge; the first shadow load is digit0.
REQ-023 SHALL, on reset mid-slot, blank the display immediately and restart the scan from digit0; no partial slot is resumed.

Verification
REQ-024 SHALL pass scan order, with CLK_DIV=8, DEAD=2, enable=1, digits=01,02,03,04: an low for 6 of every 8 cycles, sequence 1110,1101,1011,0111 repeating; seg=79,24,30,19 respectively.
REQ-025 SHALL pass dead-time check: every an transition between two lit digits passes through 1111 for exactly DEAD=2 cycles; no cycle has two an bits low.
REQ-026 SHALL pass tearing check: change digit0 from 08 to 0F at cnt=4 of slot 0 -> seg stays 00 for the rest of that slot and shows 0E from digit0's next slot.
REQ-027 SHALL pass blink/blank check: BLINK_SCANS=2, digit1=0x41 -> digit1 lit (seg=79) for 2 scans, dark for 2 scans, repeating; digit2=0x20 -> an[2] never low; digit3=0x18 -> dp=0 during slot 3.
REQ-028 SHALL pass enable check: drop enable for 3 slots -> an=1111 within one clock and idx/cnt continue; on re-enable the digit matching the running idx lights, not digit0.
REQ-029 SHALL pass mid-operation reset: assert rst during slot 2 lit -> an=1111, seg=7F, dp=1 asynchronously; after release the first lit digit is digit0 at cnt=DEAD+1.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 4-digit seven-segment driver with dead time, blank and blink.
module seg7_scan #(
  parameter int CLK_DIV     = 25000,
  parameter int DEAD        = 500,
  parameter int BLINK_SCANS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] digit0,
  input  logic [7:0] digit1,
  input  logic [7:0] digit2,
  input  logic [7:0] digit3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DL = CW'(DEAD);
  localparam logic [9:0] SL = 10'(BLINK_SCANS - 1);
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [9:0] scn;
  logic blink_phase;
  logic [7:0] shadow, sel;
  logic [3:0] an_n;
  logic dark, unused;
  assign unused = ^{digit0[7], digit1[7], digit2[7], digit3[7], shadow[7]};
  always_comb begin
    sel = idx == 2'd0 ? digit0 : idx == 2'd1 ? digit1 : idx == 2'd2 ? digit2 : digit3;
    dark = cnt < DL || !enable || shadow[5] || (shadow[6] && blink_phase);
    an_n = dark ? 4'hF : ~(4'b0001 << idx);
  end
  // Shadow is captured only at slot start so a digit never tears mid-slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      scn <= '0;
      blink_phase <= 1'b0;
      shadow <= 8'h20;
      an <= 4'hF;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      cnt <= cnt == LAST ? '0 : cnt + CW'(1);
      if (cnt == LAST) idx <= idx + 2'd1;
      if (cnt == LAST && idx == 2'd3) begin
        scn <= scn == SL ? '0 : scn + 10'd1;
        if (scn == SL) blink_phase <= ~blink_phase;
      end
      if (cnt == '0) shadow <= sel;
      an <= an_n;
      seg <= FONT[shadow[3:0]];
      dp <= ~shadow[4];
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized checks of seg7_scan against an absolute-time reference model.
module tb_seg7_scan;
  localparam int CD = 8, DT = 2, BS = 2;
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 0, rst = 1, en = 0;
  logic [7:0] dig [4];
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int checks = 0, fails = 0;
  int k;
  logic [7:0] cur;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic e_dp;

  seg7_scan #(.CLK_DIV(CD), .DEAD(DT), .BLINK_SCANS(BS)) dut (
    .clk(clk), .rst(rst), .enable(en),
    .digit0(dig[0]), .digit1(dig[1]), .digit2(dig[2]), .digit3(dig[3]),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // k counts edges since reset release: slot = k/CD, position = k%CD, blink half = k/(CD*4*BS).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0;
      cur <= 8'h20;
      e_an <= 4'hF;
      e_seg <= 7'h7F;
      e_dp <= 1'b1;
    end else begin
      k <= k + 1;
      if (k % CD == 0) cur <= dig[(k / CD) % 4];
      e_an <= ((k % CD) >= DT && en && !cur[5] && !(cur[6] && (k / (CD * 4 * BS)) % 2 == 1))
              ? ~(4'b0001 << ((k / CD) % 4)) : 4'hF;
      e_seg <= FONT[cur[3:0]];
      e_dp <= ~cur[4];
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    en = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL reset_hold an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
    end
    rst = 0;
  endtask

  task automatic test_scan_order();
    int gap = 0;
    logic [3:0] last = 4'hF;
    for (int i = 0; i < 4; i++) dig[i] = 8'(i + 1);
    en = 1;
    pulse_reset();
    repeat (96) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL scan_order k=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
      checks++;
      if ($countones(~an) > 1) begin
        fails++;
        $display("FAIL scan_onehot an=%b want at most one low", an);
      end
      if (an === 4'hF) gap++;
      else begin
        if (an !== last && last !== 4'hF) begin
          checks++;
          if (gap !== DT) begin
            fails++;
            $display("FAIL dead_time gap=%0d want %0d", gap, DT);
          end
        end
        last = an;
        gap = 0;
      end
    end
  endtask

  task automatic test_tearing();
    bit found = 0;
    dig[0] = 8'h08;
    for (int i = 1; i < 4; i++) dig[i] = 8'($urandom);
    en = 1;
    pulse_reset();
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      found = (k == 4);
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL tear_align k=%0d want 4", k);
    end
    dig[0] = 8'h0F;
    repeat (48) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL tearing k=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (k >= 5 && k <= 9) begin
        checks++;
        if (seg !== 7'h00) begin
          fails++;
          $display("FAIL tear_hold k=%0d seg=%h want 00", k, seg);
        end
      end
      if (k >= 34 && k <= 40) begin
        checks++;
        if (seg !== 7'h0E) begin
          fails++;
          $display("FAIL tear_next k=%0d seg=%h want 0e", k, seg);
        end
      end
    end
  endtask

  task automatic test_blink_blank();
    dig[0] = 8'($urandom) & 8'h1F;
    dig[1] = 8'h41;
    dig[2] = 8'h20;
    dig[3] = 8'h18;
    en = 1;
    pulse_reset();
    repeat (288) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL blink_blank k=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
      checks++;
      if (an[2] !== 1'b1) begin
        fails++;
        $display("FAIL blank_digit2 an=%b want an[2]=1", an);
      end
      if (an === 4'b1101) begin
        checks++;
        if (seg !== 7'h79 || ((k - 1) / (CD * 4 * BS)) % 2 != 0) begin
          fails++;
          $display("FAIL blink_digit1 k=%0d seg=%h want 79 in lit phase", k, seg);
        end
      end
      if (an === 4'b0111) begin
        checks++;
        if (dp !== 1'b0 || seg !== 7'h00) begin
          fails++;
          $display("FAIL dp_digit3 dp=%b seg=%h want dp=0 seg=00", dp, seg);
        end
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 4; i++) dig[i] = 8'($urandom) & 8'h1F;
    en = 1;
    repeat ($urandom_range(31)) @(negedge clk);
    en = 0;
    for (int n = 0; n < 3 * CD; n++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || {an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL enable_off n=%0d an=%b seg=%h dp=%b want an=1111 seg=%h dp=%b", n, an, seg, dp, e_seg, e_dp);
      end
    end
    en = 1;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL enable_on k=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL random k=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
      if ($urandom_range(3) == 0) dig[$urandom_range(3)] = 8'($urandom);
      if ($urandom_range(15) == 0) en = ~en;
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    int first = 0;
    for (int i = 0; i < 4; i++) dig[i] = 8'($urandom) & 8'h1F;
    en = 1;
    pulse_reset();
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      found = (k % (CD * 4) == 2 * CD + 4);
    end
    checks++;
    if (!found || an !== 4'b1011) begin
      fails++;
      $display("FAIL midrst_align k=%0d an=%b want slot 2 lit", k, an);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL midrst_async an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
    end
    @(negedge clk);
    rst = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL midrst_run k=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (first == 0 && an !== 4'hF) begin
        first = n;
        checks++;
        if (n != DT + 1 || an !== 4'b1110) begin
          fails++;
          $display("FAIL midrst_first sample=%0d an=%b want sample=%0d an=1110", n, an, DT + 1);
        end
      end
    end
    checks++;
    if (first == 0) begin
      fails++;
      $display("FAIL midrst_lit no digit lit want digit0");
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dig[i] = 8'h00;
    test_reset();
    test_scan_order();
    test_tearing();
    test_blink_blank();
    test_enable();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
